// File: rtl/sar_conv_sequencer.sv
// Synchronous sequencer for the asynchronous SAR core: drives SAMP, waits for
// the synchronised EOC, captures CODE, averages 2^AVG_LOG2 conversions and
// presents the result on a valid/ready port with sticky timeout/overrun flags.
module sar_conv_sequencer #(
  parameter int unsigned N           = 9,
  parameter int unsigned SAMP_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned AVG_LOG2    = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic         CONT,
  input  logic         CLR_FLAGS,
  input  logic         EOC,
  input  logic [N-1:0] CODE,
  output logic         SAMP,
  output logic         BUSY,
  output logic [N-1:0] DOUT,
  output logic         DVALID,
  input  logic         DREADY,
  output logic         TIMEOUT,
  output logic         OVERRUN
);

  localparam int unsigned AW = N + AVG_LOG2;
  localparam int unsigned CW = AVG_LOG2 + 1;
  localparam int unsigned SW = $clog2(SAMP_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [CW-1:0] GROUP     = CW'(1 << AVG_LOG2);
  localparam logic [SW-1:0] SAMP_LAST = SW'(SAMP_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SAMPLE,
    S_CONVERT,
    S_CAPTURE
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [SW-1:0]          r_samp_cnt;
  logic [TW-1:0]          r_timer;
  logic [AW-1:0]          r_acc;
  logic [CW-1:0]          r_cnt;

  logic                   w_eoc_s;
  logic [AW-1:0]          w_acc_next;
  logic [CW-1:0]          w_cnt_next;
  logic                   w_group_done;

  assign w_eoc_s      = r_sync[SYNC_STAGES-1];
  assign w_acc_next   = r_acc + AW'(CODE);
  assign w_cnt_next   = r_cnt + CW'(1);
  assign w_group_done = (w_cnt_next == GROUP);

  // Bring the asynchronous EOC into the CLK domain.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], EOC};
    end
  end

  // Conversion FSM with registered SAMP/BUSY and the result/flag registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      SAMP       <= 1'b1;
      BUSY       <= 1'b0;
      DOUT       <= '0;
      DVALID     <= 1'b0;
      TIMEOUT    <= 1'b0;
      OVERRUN    <= 1'b0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_samp_cnt <= '0;
      r_timer    <= '0;
    end else begin
      // Clears and handshakes come first so a same-cycle set or publish below wins.
      if (CLR_FLAGS) begin
        TIMEOUT <= 1'b0;
        OVERRUN <= 1'b0;
      end
      if (DVALID && DREADY) begin
        DVALID <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (START || CONT) begin
            r_state    <= S_SAMPLE;
            BUSY       <= 1'b1;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_samp_cnt <= '0;
          end
        end

        S_SAMPLE: begin
          if (r_samp_cnt == SAMP_LAST) begin
            r_state <= S_CONVERT;
            SAMP    <= 1'b0;
            r_timer <= '0;
          end else begin
            r_samp_cnt <= r_samp_cnt + SW'(1);
          end
        end

        S_CONVERT: begin
          if (w_eoc_s) begin
            r_state <= S_CAPTURE;
          end else if (r_timer == TMO_LAST) begin
            TIMEOUT <= 1'b1;
            r_state <= S_IDLE;
            SAMP    <= 1'b1;
            BUSY    <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end

        S_CAPTURE: begin
          SAMP       <= 1'b1;
          r_samp_cnt <= '0;
          if (!w_group_done) begin
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
            r_state <= S_SAMPLE;
          end else begin
            DOUT   <= w_acc_next[AW-1:AVG_LOG2];
            DVALID <= 1'b1;
            if (DVALID && !DREADY) begin
              OVERRUN <= 1'b1;
            end
            r_acc <= '0;
            r_cnt <= '0;
            if (CONT) begin
              r_state <= S_SAMPLE;
            end else begin
              r_state <= S_IDLE;
              BUSY    <= 1'b0;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          SAMP    <= 1'b1;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule
